// File: rtl/sw_tile_dispatcher.sv
// Initiator for a 16x16 Smith-Waterman tile solver: walks a job's tiles in raster
// order, threads tile boundaries from returned results and tracks the global maximum.
module sw_tile_dispatcher #(
  parameter int TILES_PER_SIDE = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [127:0] seq_a,
  input  logic [127:0] seq_b,
  output logic         tile_start,
  output logic [3:0]   tileNum,
  output logic [31:0]  S1,
  output logic [31:0]  S2,
  output logic [127:0] firstRow,
  output logic [127:0] firstCol,
  output logic [7:0]   diagonalCell,
  input  logic [127:0] lastRow,
  input  logic [127:0] lastCol,
  input  logic [7:0]   diagonalOut,
  input  logic [7:0]   maxValue,
  input  logic [3:0]   maxIdx,
  input  logic [3:0]   tileNumOut,
  input  logic         valid,
  output logic         done,
  output logic         error,
  output logic [7:0]   best_score,
  output logic [3:0]   best_tile,
  output logic [3:0]   best_idx
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [1:0]    LAST_IDX = 2'(TILES_PER_SIDE - 1);
  localparam logic [3:0]    TPS      = 4'(TILES_PER_SIDE);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [127:0]  seq_a_q, seq_b_q;
  logic [127:0]  row_buf [TILES_PER_SIDE];
  logic [127:0]  col_buf;
  logic [7:0]    diag_reg;
  logic [1:0]    r, c;
  logic [CW-1:0] wait_cnt;

  logic          accept, hit, bad_tag, timed_out, last_tile;
  logic [1:0]    r_nxt, c_nxt;
  logic [7:0]    diag_nxt;
  logic [127:0]  col_nxt;

  // The corner for each tile is taken from the row buffer, so the solver's own
  // bottom-right output is redundant here.
  logic unused_diag;
  assign unused_diag = ^diagonalOut;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    job_ready  = 1'b0;
    tile_start = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    hit        = 1'b0;
    bad_tag    = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        tile_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (valid) begin
          if (tileNumOut == tileNum) begin
            hit       = 1'b1;
            state_nxt = last_tile ? DONE : ISSUE;
          end else begin
            bad_tag   = 1'b1;
            state_nxt = DONE;
          end
        end else if (wait_cnt == TO_LAST) begin
          timed_out = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Raster position of the following tile and the boundary values it will need.
  always_comb begin
    last_tile = (r == LAST_IDX) && (c == LAST_IDX);
    c_nxt     = (c == LAST_IDX) ? 2'd0 : c + 2'd1;
    r_nxt     = (c == LAST_IDX) ? r + 2'd1 : r;
    diag_nxt  = (r != 2'd0) ? row_buf[c][127:120] : 8'd0;
    col_nxt   = (c_nxt == 2'd0) ? '0 : lastCol;
  end

  // NOTE: the row buffer is a handful of wide registers, so it is cleared on reset
  // like everything else and every boundary output is defined straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_a_q      <= '0;
      seq_b_q      <= '0;
      for (int i = 0; i < TILES_PER_SIDE; i++) row_buf[i] <= '0;
      col_buf      <= '0;
      diag_reg     <= '0;
      r            <= '0;
      c            <= '0;
      wait_cnt     <= '0;
      tileNum      <= '0;
      S1           <= '0;
      S2           <= '0;
      firstRow     <= '0;
      firstCol     <= '0;
      diagonalCell <= '0;
      error        <= 1'b0;
      best_score   <= '0;
      best_tile    <= '0;
      best_idx     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read in this
      // block sees the pre-edge value regardless of statement order.
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);

      if (accept) begin
        seq_a_q      <= seq_a;
        seq_b_q      <= seq_b;
        for (int i = 0; i < TILES_PER_SIDE; i++) row_buf[i] <= '0;
        col_buf      <= '0;
        diag_reg     <= '0;
        r            <= '0;
        c            <= '0;
        error        <= 1'b0;
        best_score   <= '0;
        best_tile    <= '0;
        best_idx     <= '0;
        tileNum      <= '0;
        S1           <= seq_a[31:0];
        S2           <= seq_b[31:0];
        firstRow     <= '0;
        firstCol     <= '0;
        diagonalCell <= '0;
      end

      if (hit) begin
        row_buf[c] <= lastRow;
        col_buf    <= col_nxt;
        diag_reg   <= diag_nxt;
        r          <= r_nxt;
        c          <= c_nxt;
        // Strict compare: on a tie the earlier tile keeps the title.
        if (maxValue > best_score) begin
          best_score <= maxValue;
          best_tile  <= tileNum;
          best_idx   <= maxIdx;
        end
        if (!last_tile) begin
          tileNum      <= 4'(r_nxt) * TPS + 4'(c_nxt);
          S1           <= seq_a_q[{r_nxt, 5'd0} +: 32];
          S2           <= seq_b_q[{c_nxt, 5'd0} +: 32];
          firstRow     <= (r_nxt == 2'd0) ? '0 :
                          (c_nxt == c)    ? lastRow : row_buf[c_nxt];
          firstCol     <= col_nxt;
          diagonalCell <= (r_nxt == 2'd0 || c_nxt == 2'd0) ? 8'd0 : diag_nxt;
        end
      end

      if (bad_tag || timed_out) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sw_tile_dispatcher.sv
// Directed bench for sw_tile_dispatcher: a behavioural solver answers each tile
// three cycles after tile_start with tile-tagged boundary patterns.
module tb_sw_tile_dispatcher;

  localparam logic [127:0] SA = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] SB = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic         clk = 1'b0;
  logic         reset;
  logic         job_valid;
  logic         job_ready;
  logic [127:0] seq_a, seq_b;
  logic         tile_start;
  logic [3:0]   tileNum;
  logic [31:0]  S1, S2;
  logic [127:0] firstRow, firstCol;
  logic [7:0]   diagonalCell;
  logic [127:0] lastRow, lastCol;
  logic [7:0]   diagonalOut, maxValue;
  logic [3:0]   maxIdx, tileNumOut;
  logic         valid;
  logic         done, error;
  logic [7:0]   best_score;
  logic [3:0]   best_tile, best_idx;

  sw_tile_dispatcher dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .seq_a(seq_a), .seq_b(seq_b), .tile_start(tile_start), .tileNum(tileNum),
    .S1(S1), .S2(S2), .firstRow(firstRow), .firstCol(firstCol),
    .diagonalCell(diagonalCell), .lastRow(lastRow), .lastCol(lastCol),
    .diagonalOut(diagonalOut), .maxValue(maxValue), .maxIdx(maxIdx),
    .tileNumOut(tileNumOut), .valid(valid), .done(done), .error(error),
    .best_score(best_score), .best_tile(best_tile), .best_idx(best_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] row_pat(input logic [3:0] t);
    logic [127:0] p;
    for (int k = 0; k < 16; k++) p[8*k +: 8] = {t, 4'(k)};
    return p;
  endfunction

  function automatic logic [127:0] col_pat(input logic [3:0] t);
    logic [127:0] p;
    for (int k = 0; k < 16; k++) p[8*k +: 8] = {4'(k), t};
    return p;
  endfunction

  // 0: maxValue=2*tile, 1: 50 on tiles 3 and 9, 2: never answer, 3: wrong tag on tile 2
  int           resp_mode = 0;
  int           n_starts  = 0;
  int           order  [16];
  int           st_cyc [16];
  logic [127:0] fr [16];
  logic [127:0] fc [16];
  logic [7:0]   dg [16];
  logic [31:0]  s1r [16];
  logic [31:0]  s2r [16];
  logic         err_first;
  logic [3:0]   mt;

  initial begin
    valid = 1'b0; lastRow = '0; lastCol = '0; diagonalOut = '0;
    maxValue = '0; maxIdx = '0; tileNumOut = '0;
    forever begin
      @(negedge clk);
      while (tile_start === 1'b1) begin
        mt = tileNum;
        if (n_starts == 0) err_first = error;
        if (n_starts < 16) begin
          order[n_starts]  = int'(mt);
          st_cyc[n_starts] = cyc;
        end
        fr[mt] = firstRow; fc[mt] = firstCol; dg[mt] = diagonalCell;
        s1r[mt] = S1; s2r[mt] = S2;
        n_starts++;
        if (resp_mode == 2) break;
        repeat (3) @(negedge clk);
        lastRow     = row_pat(mt);
        lastCol     = col_pat(mt);
        diagonalOut = 8'hEE;
        maxValue    = (resp_mode == 1) ? ((mt == 4'd3 || mt == 4'd9) ? 8'd50 : 8'(mt))
                                       : 8'(mt) * 8'd2;
        maxIdx      = mt ^ 4'h5;
        tileNumOut  = (resp_mode == 3 && mt == 4'd2) ? 4'd3 : mt;
        valid       = 1'b1;
        @(negedge clk);
        valid = 1'b0;
      end
    end
  end

  int   done_cnt = 0;
  int   done_cyc = 0;
  logic done_err;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = error;
    end
  end

  task automatic start_job(input int mode);
    int k = 0;
    while (job_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    resp_mode = mode;
    n_starts  = 0;
    done_cnt  = 0;
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check(tag, done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   k;
    reset = 1'b0; job_valid = 1'b1; seq_a = SA; seq_b = SB;
    repeat (3) @(negedge clk);
    check("rst_job_ready", job_ready, 1);
    check("rst_starts", n_starts, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_best", {best_score, best_tile, best_idx}, 0);
    check("rst_tile_out", {tileNum, S1, S2, diagonalCell}, 0);
    check("rst_boundaries", firstRow | firstCol, 0);

    // Job A: plain run, held job_valid accepted on the first edge after reset.
    reset = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    check("accept_latency", tile_start, 1);
    wait_done("a_done_once", 400);
    check("a_starts", n_starts, 16);
    ok = 1'b1;
    for (int i = 0; i < 16; i++) if (order[i] != i) ok = 1'b0;
    check("a_tile_order", ok, 1);
    check("a_valid_to_start", st_cyc[1] - st_cyc[0], 4);
    check("a_valid_to_done", done_cyc - st_cyc[15], 4);
    check("a_best_score", best_score, 8'd30);
    check("a_best_tile", best_tile, 4'd15);
    check("a_best_idx", best_idx, 4'hA);
    check("a_error", error, 0);
    check("a_done_err", done_err, 0);
    check("a_t5_first_row", fr[5], row_pat(4'd1));
    check("a_t5_first_col", fc[5], col_pat(4'd4));
    check("a_t5_diag", dg[5], 8'h0F);
    check("a_t10_diag", dg[10], 8'h5F);
    check("a_t15_diag", dg[15], 8'hAF);
    check("a_t13_first_row", fr[13], row_pat(4'd9));
    check("a_row0_first_row", fr[0] | fr[1] | fr[2] | fr[3], 0);
    check("a_col0_first_col", fc[0] | fc[4] | fc[8] | fc[12], 0);
    check("a_edge_diag", {dg[1], dg[4], dg[12]}, 0);
    check("a_t6_s1", s1r[6], 32'hFEDCBA98);
    check("a_t6_s2", s2r[6], 32'h44556677);

    // Job B: equal maxima on tiles 3 and 9.
    start_job(1);
    wait_done("b_done_once", 400);
    check("b_best_score", best_score, 8'd50);
    check("b_best_tile", best_tile, 4'd3);
    check("b_best_idx", best_idx, 4'h6);

    // Job C: solver never answers.
    start_job(2);
    wait_done("c_done_once", 400);
    check("c_starts", n_starts, 1);
    check("c_error", error, 1);
    check("c_done_err", done_err, 1);
    check("c_timeout_latency", done_cyc - st_cyc[0], 256);
    check("c_best_cleared", best_score, 0);

    // Job D: echoed tag wrong on tile 2.
    start_job(3);
    check("d_error_cleared", err_first, 0);
    wait_done("d_done_once", 400);
    repeat (10) @(negedge clk);
    check("d_starts", n_starts, 3);
    check("d_error_held", error, 1);
    check("d_best_score", best_score, 8'd2);
    check("d_best_tile", best_tile, 4'd1);

    // Job E: reset pulse while tile 7 is outstanding.
    start_job(0);
    k = 0;
    while (n_starts < 8 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("e_reach_tile7", n_starts, 8);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("e_rst_job_ready", job_ready, 1);
    check("e_rst_best", best_score, 0);
    check("e_rst_first_row", firstRow, 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("e_no_done", done_cnt, 0);
    check("e_idle", job_ready, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/sw_tile_dispatcher.md
Name: sw_tile_dispatcher

Overview:
- Initiator side of the 16x16 Smith-Waterman tile-solver interface.
- Accepts one alignment job: two 64-character sequences, 2 bits per base.
- Issues the 16 tiles to the solver in raster order and feeds each tile's boundary from previously returned lastRow/lastCol/diagonalOut.
- Tracks the global maximum score and its location, then reports completion.

Parameters:
- TILES_PER_SIDE, 4, tiles per matrix side; legal range 1..4 because tileNum is 4 bits.
- TIMEOUT, 255, maximum cycles to wait for solver valid before flagging an error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  dispatcher idle, can accept a job
- seq_a  in  128  row sequence; char k at [2k+1:2k]
- seq_b  in  128  column sequence; same packing
- tile_start  out  1  one-cycle pulse; tile inputs are valid
- tileNum  out  4  tile index r*TILES_PER_SIDE+c
- S1  out  32  seq_a[32r+31:32r]
- S2  out  32  seq_b[32c+31:32c]
- firstRow  out  128  top boundary; cell k at [8k+7:8k]
- firstCol  out  128  left boundary; same packing
- diagonalCell  out  8  top-left corner value
- lastRow  in  128  solver bottom row
- lastCol  in  128  solver right column
- diagonalOut  in  8  solver bottom-right cell
- maxValue  in  8  tile maximum
- maxIdx  in  4  position of the tile maximum
- tileNumOut  in  4  echoed tile index
- valid  in  1  solver result strobe
- done  out  1  one-cycle job-complete pulse
- error  out  1  held with done; cleared at next job accept
- best_score  out  8  global max
- best_tile  out  4  tile of global max
- best_idx  out  4  maxIdx of global max

Behaviour:
- Reset (async, reset=0): FSM→IDLE; job_ready=1; tile_start, done, error=0; all tile outputs, row buffer, column buffer, diagonal register and best_* = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - job_ready=1.
  - On job_valid: latch seq_a/seq_b; clear buffers, best_*, error; r=c=0; go to ISSUE next cycle.
- ISSUE:
  - tile_start=1 for exactly one cycle; go to WAIT.
  - tileNum/S1/S2/firstRow/firstCol/diagonalCell are registered.
  - They are stable from the ISSUE cycle until the next ISSUE.
- Boundary selection for tile (r,c):
  - firstRow = 0 if r=0, else row_buf[c].
  - firstCol = 0 if c=0, else col_buf.
  - diagonalCell = 0 if r=0 or c=0, else diag_reg.
- WAIT:
  - Timeout counter increments each cycle.
  - If valid and tileNumOut==tileNum, capture in the same edge:
    - diag_reg ← row_buf[c][127:120] (old value, before overwrite) when r>0, else 0. This captured value is the corner used by tile (r,c+1).
    - row_buf[c] ← lastRow.
    - col_buf ← lastCol; reset to 0 at the start of each tile row.
    - If maxValue > best_score (strict), update best_score/best_tile/best_idx. Ties keep the earlier tile.
    - Advance c; wrap c→0 and r+1 at TILES_PER_SIDE.
    - Go to ISSUE, or to DONE after the last tile.
  - If valid and tileNumOut≠tileNum: error=1 → DONE.
  - If the counter reaches TIMEOUT with no valid: error=1 → DONE.
- DONE:
  - done=1 for one cycle; best_* and error hold; → IDLE.
- valid outside WAIT is ignored.
- job_valid outside IDLE is ignored (job_ready=0).
- Latency:
  - job accept → first tile_start: 1 cycle.
  - valid → next tile_start: 1 cycle.
  - Last valid → done: 1 cycle.
- Reset asserted mid-job aborts immediately; no done pulse is produced.

Test Plan:
- Reset with job_valid=1 → all outputs 0, job_ready=1; the first accept occurs only after reset deasserts.
- Solver model responds 3 cycles after each tile_start with maxValue=tileNum*2 → 16 tile_starts, tileNum 0..15 in order; done pulses once; best_score=30, best_tile=15; error=0.
- Model returns lastRow=tile-tagged patterns → tile 5 firstRow=lastRow of tile 1, firstCol=lastCol of tile 4, diagonalCell=lastRow(tile 0)[127:120]; tiles 0-3 firstRow=0; tiles 0,4,8,12 firstCol=0.
- maxValue=50 on tiles 3 and 9 and lower elsewhere → best_tile=3 (tie keeps earlier).
- Model never asserts valid → error=1 and done exactly TIMEOUT+1 cycles after tile_start; the next job clears error.
- tileNumOut wrong on tile 2 → error and done; no further tile_start. Reset pulse during tile 7 → IDLE with no done.
